// File: rtl/id_exe_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// id_exe_reg : ID/EXE pipeline register with freeze, flush, bubble insertion
//              and saturating issue/bubble performance counters.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module id_exe_reg #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              hazard,
  input  logic              cond_pass,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       val_rn_in,
  input  logic [31:0]       val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic              carry_in,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic [3:0]        exe_cmd_out,
  output logic [31:0]       pc_out,
  output logic [31:0]       val_rn_out,
  output logic [31:0]       val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic              carry_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic do_bubble;
  logic do_load;
  logic do_issue;
  logic [3:0] exe_cmd_clean;

  assign do_bubble     = hazard | ~cond_pass;
  assign do_load       = ~flush & ~freeze;
  assign do_issue      = do_load & ~do_bubble;
  // A branch never carries an EXE command; stop undefined encodings here.
  assign exe_cmd_clean = b_in ? 4'b0000 : exe_cmd_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      b_out        <= 1'b0;
      s_out        <= 1'b0;
      exe_cmd_out  <= 4'b0000;
      valid_out    <= 1'b0;
    end else if (flush || (do_load && do_bubble)) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      b_out        <= 1'b0;
      s_out        <= 1'b0;
      exe_cmd_out  <= 4'b0000;
      valid_out    <= 1'b0;
    end else if (do_issue) begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      mem_w_en_out <= mem_w_en_in;
      b_out        <= b_in;
      s_out        <= s_in;
      exe_cmd_out  <= exe_cmd_clean;
      valid_out    <= 1'b1;
    end
  end

  // Bubbles still load data and tags so forwarding compares stay coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out            <= 32'h0;
      val_rn_out        <= 32'h0;
      val_rm_out        <= 32'h0;
      imm_out           <= 1'b0;
      shift_operand_out <= 12'h0;
      signed_imm_24_out <= 24'h0;
      dest_out          <= 4'h0;
      src1_out          <= 4'h0;
      src2_out          <= 4'h0;
      carry_out         <= 1'b0;
    end else if (flush) begin
      pc_out            <= 32'h0;
      val_rn_out        <= 32'h0;
      val_rm_out        <= 32'h0;
      imm_out           <= 1'b0;
      shift_operand_out <= 12'h0;
      signed_imm_24_out <= 24'h0;
      dest_out          <= 4'h0;
      src1_out          <= 4'h0;
      src2_out          <= 4'h0;
      carry_out         <= 1'b0;
    end else if (!freeze) begin
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      imm_out           <= imm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm_24_out <= signed_imm_24_in;
      dest_out          <= dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      carry_out         <= carry_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (do_issue && (issue_cnt != CNT_MAX)) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (do_load && do_bubble && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_exe_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_id_exe_reg : directed plus randomized checks of id_exe_reg against a
//                 behavioural model of the pipeline-register rules.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_id_exe_reg;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, freeze, flush, hazard, cond_pass;
  logic wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, carry_in;
  logic [3:0] exe_cmd_in, dest_in, src1_in, src2_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;

  logic wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, carry_out, valid_out;
  logic [3:0] exe_cmd_out, dest_out, src1_out, src2_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic [CW-1:0] issue_cnt, bubble_cnt;

  id_exe_reg #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
    .cond_pass(cond_pass), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .carry_in(carry_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out), .pc_out(pc_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .carry_out(carry_out), .valid_out(valid_out), .issue_cnt(issue_cnt),
    .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic wb, mr, mw, b, s, imm, c, v;
    logic [3:0] cmd, d, s1, s2;
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic [23:0] si;
    int ic, bc;
  } model_t;

  model_t m;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic model_t zero_model();
    model_t z;
    z = '{default: '0};
    return z;
  endfunction

  // Architectural effect of one rising edge, given the current input values.
  function automatic model_t next_model(input model_t cur);
    model_t n = cur;
    if (flush) begin
      n = zero_model();
      n.ic = cur.ic;
      n.bc = cur.bc;
    end else if (!freeze) begin
      n.pc = pc_in;  n.rn = val_rn_in;  n.rm = val_rm_in;  n.imm = imm_in;
      n.sh = shift_operand_in;  n.si = signed_imm_24_in;
      n.d = dest_in;  n.s1 = src1_in;  n.s2 = src2_in;  n.c = carry_in;
      if (hazard || !cond_pass) begin
        {n.wb, n.mr, n.mw, n.b, n.s, n.v} = '0;
        n.cmd = 4'd0;
        if (cur.bc < CMAX) n.bc = cur.bc + 1;
      end else begin
        n.wb = wb_en_in;  n.mr = mem_r_en_in;  n.mw = mem_w_en_in;
        n.b = b_in;  n.s = s_in;  n.v = 1'b1;
        n.cmd = b_in ? 4'd0 : exe_cmd_in;
        if (cur.ic < CMAX) n.ic = cur.ic + 1;
      end
    end
    return n;
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, ".wb_en"}, wb_en_out, m.wb);
    chk({ctx, ".mem_r_en"}, mem_r_en_out, m.mr);
    chk({ctx, ".mem_w_en"}, mem_w_en_out, m.mw);
    chk({ctx, ".b"}, b_out, m.b);
    chk({ctx, ".s"}, s_out, m.s);
    chk({ctx, ".exe_cmd"}, exe_cmd_out, m.cmd);
    chk({ctx, ".pc"}, pc_out, m.pc);
    chk({ctx, ".val_rn"}, val_rn_out, m.rn);
    chk({ctx, ".val_rm"}, val_rm_out, m.rm);
    chk({ctx, ".imm"}, imm_out, m.imm);
    chk({ctx, ".shift_op"}, shift_operand_out, m.sh);
    chk({ctx, ".simm24"}, signed_imm_24_out, m.si);
    chk({ctx, ".dest"}, dest_out, m.d);
    chk({ctx, ".src1"}, src1_out, m.s1);
    chk({ctx, ".src2"}, src2_out, m.s2);
    chk({ctx, ".carry"}, carry_out, m.c);
    chk({ctx, ".valid"}, valid_out, m.v);
    chk({ctx, ".issue_cnt"}, issue_cnt, m.ic[CW-1:0]);
    chk({ctx, ".bubble_cnt"}, bubble_cnt, m.bc[CW-1:0]);
  endtask

  // One rising edge: advance the model, then compare just after the edge.
  task automatic step(input string ctx);
    @(posedge clk);
    m = next_model(m);
    #1;
    check_all(ctx);
  endtask

  task automatic zero_inputs();
    {freeze, flush, hazard} = '0;
    cond_pass = 1'b1;
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, carry_in} = '0;
    {exe_cmd_in, dest_in, src1_in, src2_in} = '0;
    {pc_in, val_rn_in, val_rm_in} = '0;
    shift_operand_in = '0;
    signed_imm_24_in = '0;
  endtask

  task automatic rand_data();
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, carry_in} = 7'($urandom);
    exe_cmd_in = 4'($urandom);  dest_in = 4'($urandom);
    src1_in = 4'($urandom);     src2_in = 4'($urandom);
    pc_in = $urandom;  val_rn_in = $urandom;  val_rm_in = $urandom;
    shift_operand_in = 12'($urandom);
    signed_imm_24_in = 24'($urandom);
  endtask

  initial begin
    rst = 1'b0;
    zero_inputs();
    m = zero_model();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Load all-ones twice, then assert reset mid-cycle.
    {freeze, flush, hazard} = '0;
    cond_pass = 1'b1;
    {wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm_in, carry_in} = '1;
    b_in = 1'b0;
    {exe_cmd_in, dest_in, src1_in, src2_in} = '1;
    {pc_in, val_rn_in, val_rm_in} = '1;
    shift_operand_in = '1;
    signed_imm_24_in = '1;
    step("ones1");
    step("ones2");
    chk("ones.issue_cnt", issue_cnt, 2);
    #3 rst = 1'b0;
    {freeze, flush, hazard, b_in} = '1;
    #1;
    m = zero_model();
    check_all("async_reset");
    #2 rst = 1'b1;

    // Plain ADD load after reset release.
    zero_inputs();
    exe_cmd_in = 4'b0010;  wb_en_in = 1'b1;  dest_in = 4'd3;  pc_in = 32'h10;
    step("add");
    chk("add.exe_cmd", exe_cmd_out, 4'b0010);
    chk("add.pc", pc_out, 32'h10);
    chk("add.issue_cnt", issue_cnt, 1);

    // LDR with hazard, then with failed condition.
    zero_inputs();
    mem_r_en_in = 1'b1;  wb_en_in = 1'b1;  src1_in = 4'd2;  exe_cmd_in = 4'b0010;
    hazard = 1'b1;
    step("hazard");
    chk("hazard.src1", src1_out, 4'd2);
    chk("hazard.bubble_cnt", bubble_cnt, 1);
    hazard = 1'b0;  cond_pass = 1'b0;
    step("condfail");
    chk("condfail.mem_r_en", mem_r_en_out, 1'b0);
    chk("condfail.bubble_cnt", bubble_cnt, 2);

    // Flush beats freeze while STR is presented.
    zero_inputs();
    mem_w_en_in = 1'b1;  exe_cmd_in = 4'b0010;  pc_in = 32'h44;  src1_in = 4'd5;
    flush = 1'b1;  freeze = 1'b1;
    step("flush_freeze");
    chk("flush.src1", src1_out, 4'd0);

    // Load SUB, freeze 3 cycles with MOV presented, then release.
    zero_inputs();
    exe_cmd_in = 4'b0100;  wb_en_in = 1'b1;  pc_in = 32'h20;
    step("sub");
    exe_cmd_in = 4'b0001;  pc_in = 32'h24;  freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("freeze");
      chk("freeze.exe_cmd", exe_cmd_out, 4'b0100);
    end
    freeze = 1'b0;
    step("mov");
    chk("mov.exe_cmd", exe_cmd_out, 4'b0001);

    // Flush glitch between edges has no effect.
    #2 flush = 1'b1;
    #2 flush = 1'b0;
    step("glitch");

    // Branch sanitising.
    zero_inputs();
    b_in = 1'b1;  exe_cmd_in = 4'b1111;
    step("branch");
    chk("branch.b", b_out, 1'b1);
    chk("branch.exe_cmd", exe_cmd_out, 4'b0000);

    // Counter saturation for both counters.
    zero_inputs();
    for (int k = 0; k < 20; k++) begin
      rand_data();
      step("sat_issue");
    end
    chk("sat.issue_cnt", issue_cnt, CMAX);
    hazard = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rand_data();
      step("sat_bubble");
    end
    chk("sat.bubble_cnt", bubble_cnt, CMAX);

    // Randomized traffic with occasional mid-cycle async resets.
    for (int k = 0; k < 400; k++) begin
      rand_data();
      flush     = ($urandom_range(0, 9) == 0);
      freeze    = ($urandom_range(0, 4) == 0);
      hazard    = ($urandom_range(0, 5) == 0);
      cond_pass = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b0;
        #1;
        m = zero_model();
        check_all("rand_reset");
        #1 rst = 1'b1;
      end
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
